memory_decoder: RTL and testbench



---
 rtl/memory_decoder_if.sv | 30 +++
 rtl/memory_decoder.sv | 62 ++++++
 tb/tb_memory_decoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/memory_decoder_if.sv
// Bank-select bus for memory_decoder: select index in, one-hot selects,
// registered select, change strobe and per-bank counters out.
interface memory_decoder_if #(
   parameter int CNT_W = 8
);
   logic             mem_in1;
   logic             mem_in0;
   logic             mem_out3;
   logic             mem_out2;
   logic             mem_out1;
   logic             mem_out0;
   logic [3:0]       mem_sel_q;
   logic             bank_chg;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic [CNT_W-1:0] cnt2;
   logic [CNT_W-1:0] cnt3;

   modport master (
      output mem_in1, mem_in0,
      input  mem_out3, mem_out2, mem_out1, mem_out0,
      input  mem_sel_q, bank_chg, cnt0, cnt1, cnt2, cnt3
   );

   modport slave (
      input  mem_in1, mem_in0,
      output mem_out3, mem_out2, mem_out1, mem_out0,
      output mem_sel_q, bank_chg, cnt0, cnt1, cnt2, cnt3
   );
endinterface

// File: rtl/memory_decoder.sv
// Two-to-four one-hot bank decoder with a clocked side-path: registered select,
// bank-change strobe and per-bank saturating selection counters.
module memory_decoder #(
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   memory_decoder_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       idx;
   logic [3:0]       sel;
   logic [3:0]       sel_q;
   logic             bank_chg_q;
   logic [CNT_W-1:0] cnt_q [4];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign idx = {bus.mem_in1, bus.mem_in0};

   // Unknown select bits propagate as X on every bank line rather than picking a bank.
   always_comb begin
      sel = 'x;
      case (idx)
         2'b00:   sel = 4'b0001;
         2'b01:   sel = 4'b0010;
         2'b10:   sel = 4'b0100;
         2'b11:   sel = 4'b1000;
         default: sel = 'x;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= 4'b0000;
         bank_chg_q <= 1'b0;
         for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      end else begin
         sel_q      <= sel;
         bank_chg_q <= (sel != sel_q);
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) cnt_q[b] <= sat_inc(cnt_q[b]);
         end
      end
   end

   assign bus.mem_out3  = sel[3];
   assign bus.mem_out2  = sel[2];
   assign bus.mem_out1  = sel[1];
   assign bus.mem_out0  = sel[0];
   assign bus.mem_sel_q = sel_q;
   assign bus.bank_chg  = bank_chg_q;
   assign bus.cnt0      = cnt_q[0];
   assign bus.cnt1      = cnt_q[1];
   assign bus.cnt2      = cnt_q[2];
   assign bus.cnt3      = cnt_q[3];

endmodule

// File: tb/tb_memory_decoder.sv
// Directed, table-driven bench for memory_decoder: a default-width instance
// and a CNT_W=2 instance for counter saturation.
module tb_memory_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   memory_decoder_if #(.CNT_W(8)) bus_a ();
   memory_decoder_if #(.CNT_W(2)) bus_b ();

   memory_decoder #(.CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   memory_decoder #(.CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   typedef struct {
      logic [1:0] idx;
      logic [3:0] exp_comb;
   } comb_vec_t;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] exp_sel;
      logic       exp_chg;
   } seq_vec_t;

   int n_checks = 0;
   int n_errors = 0;

   comb_vec_t cv [4];
   seq_vec_t  sv [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One full clock cycle; returns 3 ns after the falling edge.
   task automatic cycle();
      clk = 1'b1;
      #2;
      clk = 1'b0;
      #3;
   endtask

   task automatic set_a(input logic [1:0] idx);
      bus_a.mem_in1 = idx[1];
      bus_a.mem_in0 = idx[0];
   endtask

   task automatic set_b(input logic [1:0] idx);
      bus_b.mem_in1 = idx[1];
      bus_b.mem_in0 = idx[0];
   endtask

   function automatic logic [3:0] comb_a();
      return {bus_a.mem_out3, bus_a.mem_out2, bus_a.mem_out1, bus_a.mem_out0};
   endfunction

   initial begin
      cv[0] = '{idx: 2'b00, exp_comb: 4'b0001};
      cv[1] = '{idx: 2'b01, exp_comb: 4'b0010};
      cv[2] = '{idx: 2'b10, exp_comb: 4'b0100};
      cv[3] = '{idx: 2'b11, exp_comb: 4'b1000};

      sv[0] = '{idx: 2'b00, exp_sel: 4'b0001, exp_chg: 1'b1};
      sv[1] = '{idx: 2'b01, exp_sel: 4'b0010, exp_chg: 1'b1};
      sv[2] = '{idx: 2'b01, exp_sel: 4'b0010, exp_chg: 1'b0};
      sv[3] = '{idx: 2'b11, exp_sel: 4'b1000, exp_chg: 1'b1};
      sv[4] = '{idx: 2'b00, exp_sel: 4'b0001, exp_chg: 1'b1};

      set_a(2'b00);
      set_b(2'b00);

      // Combinational sweep with the clock stopped and reset held.
      for (int i = 0; i < 4; i++) begin
         set_a(cv[i].idx);
         #5;
         chk($sformatf("comb_idx%0d", i), 32'(comb_a()), 32'(cv[i].exp_comb));
      end

      // Reset values, clock stopped.
      chk("rst_sel_q", 32'(bus_a.mem_sel_q), 32'h0);
      chk("rst_bank_chg", 32'(bus_a.bank_chg), 32'h0);
      chk("rst_cnt0", 32'(bus_a.cnt0), 32'h0);
      chk("rst_cnt1", 32'(bus_a.cnt1), 32'h0);
      chk("rst_cnt2", 32'(bus_a.cnt2), 32'h0);
      chk("rst_cnt3", 32'(bus_a.cnt3), 32'h0);
      set_a(2'b01);
      #5;
      chk("rst_comb_follow", 32'(comb_a()), 32'h2);

      // Registered path: hold idx=10 for three edges.
      set_a(2'b10);
      #2;
      rst = 1'b0;
      #3;
      for (int e = 1; e <= 3; e++) begin
         cycle();
         chk($sformatf("hold_sel_q_e%0d", e), 32'(bus_a.mem_sel_q), 32'h4);
         chk($sformatf("hold_chg_e%0d", e), 32'(bus_a.bank_chg), (e == 1) ? 32'h1 : 32'h0);
         chk($sformatf("hold_cnt2_e%0d", e), 32'(bus_a.cnt2), 32'(e));
      end
      chk("hold_cnt0", 32'(bus_a.cnt0), 32'h0);
      chk("hold_cnt1", 32'(bus_a.cnt1), 32'h0);
      chk("hold_cnt3", 32'(bus_a.cnt3), 32'h0);

      // Asynchronous reset between edges with counters nonzero.
      #1;
      rst = 1'b1;
      #1;
      chk("async_sel_q", 32'(bus_a.mem_sel_q), 32'h0);
      chk("async_chg", 32'(bus_a.bank_chg), 32'h0);
      chk("async_cnt2", 32'(bus_a.cnt2), 32'h0);
      chk("async_cnts", 32'({bus_a.cnt0, bus_a.cnt1, bus_a.cnt3}), 32'h0);
      chk("async_comb", 32'(comb_a()), 32'h4);
      rst = 1'b0;
      #1;

      // Bank switching sequence.
      for (int i = 0; i < 5; i++) begin
         set_a(sv[i].idx);
         cycle();
         chk($sformatf("sw_sel_q_%0d", i), 32'(bus_a.mem_sel_q), 32'(sv[i].exp_sel));
         chk($sformatf("sw_chg_%0d", i), 32'(bus_a.bank_chg), 32'(sv[i].exp_chg));
      end
      chk("sw_cnt0", 32'(bus_a.cnt0), 32'h2);
      chk("sw_cnt1", 32'(bus_a.cnt1), 32'h2);
      chk("sw_cnt2", 32'(bus_a.cnt2), 32'h0);
      chk("sw_cnt3", 32'(bus_a.cnt3), 32'h1);

      // Saturation on the 2-bit instance.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_b(2'b01);
      #1;
      for (int e = 1; e <= 6; e++) begin
         cycle();
         chk($sformatf("sat_cnt1_e%0d", e), 32'(bus_b.cnt1), (e < 3) ? 32'(e) : 32'h3);
      end
      chk("sat_cnt0", 32'(bus_b.cnt0), 32'h0);
      chk("sat_cnt2", 32'(bus_b.cnt2), 32'h0);
      chk("sat_cnt3", 32'(bus_b.cnt3), 32'h0);
      chk("sat_sel_q", 32'(bus_b.mem_sel_q), 32'h2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
